// File: rtl/keyboard_decoder.sv
// keyboard_decoder
// Receives PS/2 frames from a keyboard and turns them into game commands.
// It checks and unpacks each 11-bit frame, follows the E0 and F0 prefixes,
// and updates the two player direction registers and the start pulse.
//
// Ports:
//   clk           in  1  system clock; all logic runs on its rising edge
//   rst_n         in  1  asynchronous active-low reset
//   keyboardCLK   in  1  raw PS/2 clock (asynchronous)
//   keyboardData  in  1  raw PS/2 data (asynchronous)
//   scanCode      out 8  last accepted byte; holds its value between frames
//   scanValid     out 1  one-cycle pulse for every accepted byte
//   frameError    out 1  one-cycle pulse on a parity, stop or timeout failure
//   p1Dir         out 2  player 1 direction (00 up, 01 right, 10 down, 11 left)
//   p2Dir         out 2  player 2 direction (same encoding)
//   startPressed  out 1  one-cycle pulse on the first make of Space
module keyboard_decoder #(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       keyboardCLK,
  input  logic       keyboardData,
  output logic [7:0] scanCode,
  output logic       scanValid,
  output logic       frameError,
  output logic [1:0] p1Dir,
  output logic [1:0] p2Dir,
  output logic       startPressed
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  // Ignore a direction request that would turn a player straight back on itself.
  function automatic logic [1:0] next_dir(input logic [1:0] cur, input logic [1:0] req);
    logic [1:0] res;
    if (req == (cur ^ 2'b10)) begin
      res = cur;
    end else begin
      res = req;
    end
    return res;
  endfunction

  logic [1:0]  clk_sync_q, data_sync_q;
  logic        clk_prev_q;
  logic        fall_s, data_s;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        stop_q, stop_d;
  logic [15:0] tmo_q, tmo_d;

  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic        space_q, space_d;

  logic [7:0]  scan_code_q, scan_code_d;
  logic        scan_valid_q, scan_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  p1_dir_q, p1_dir_d;
  logic [1:0]  p2_dir_q, p2_dir_d;
  logic        start_q, start_d;

  assign data_s = data_sync_q[1];
  assign fall_s = clk_prev_q & ~clk_sync_q[1];

  // Two-stage synchronisers and the previous-clock register. All reset to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], keyboardCLK};
      data_sync_q <= {data_sync_q[0], keyboardData};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  // State registers for the frame FSM, the prefix flags and the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      stop_q       <= 1'b0;
      tmo_q        <= 16'd0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      space_q      <= 1'b0;
      scan_code_q  <= 8'h00;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      p1_dir_q     <= 2'b01;
      p2_dir_q     <= 2'b11;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      stop_q       <= stop_d;
      tmo_q        <= tmo_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      space_q      <= space_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
      p1_dir_q     <= p1_dir_d;
      p2_dir_q     <= p2_dir_d;
      start_q      <= start_d;
    end
  end

  // Frame FSM next-state logic plus decoding of accepted bytes.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    stop_d       = stop_q;
    tmo_d        = tmo_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    space_d      = space_q;
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    p1_dir_d     = p1_dir_q;
    p2_dir_d     = p2_dir_q;
    start_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fall_s && !data_s) begin
          bit_cnt_d = 4'd0;
          tmo_d     = 16'd0;
          state_d   = ST_RECV;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RECV: begin
        if (fall_s) begin
          tmo_d     = 16'd0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd8) begin
            shift_d = {data_s, shift_q[7:1]};  // LSB arrives first
          end else if (bit_cnt_q == 4'd8) begin
            par_d = data_s;
          end else begin
            stop_d  = data_s;
            state_d = ST_DONE;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Keyboard stalled mid-frame: drop the partial byte.
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        // Odd parity: data plus parity must hold an odd number of ones.
        if (stop_q && (^{shift_q, par_q})) begin
          scan_valid_d = 1'b1;
          scan_code_d  = shift_q;
          if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
          end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
          end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (!brk_q) begin
              if (!ext_q) begin
                case (shift_q)
                  8'h1D:   p1_dir_d = next_dir(p1_dir_q, 2'b00);
                  8'h23:   p1_dir_d = next_dir(p1_dir_q, 2'b01);
                  8'h1B:   p1_dir_d = next_dir(p1_dir_q, 2'b10);
                  8'h1C:   p1_dir_d = next_dir(p1_dir_q, 2'b11);
                  8'h29: begin
                    // Only the first make of a hold starts the game; typematic repeats do not.
                    start_d = ~space_q;
                    space_d = 1'b1;
                  end
                  default: p1_dir_d = p1_dir_q;
                endcase
              end else begin
                case (shift_q)
                  8'h75:   p2_dir_d = next_dir(p2_dir_q, 2'b00);
                  8'h74:   p2_dir_d = next_dir(p2_dir_q, 2'b01);
                  8'h72:   p2_dir_d = next_dir(p2_dir_q, 2'b10);
                  8'h6B:   p2_dir_d = next_dir(p2_dir_q, 2'b11);
                  default: p2_dir_d = p2_dir_q;
                endcase
              end
            end else if (!ext_q && (shift_q == 8'h29)) begin
              space_d = 1'b0;
            end else begin
              space_d = space_q;
            end
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign scanCode     = scan_code_q;
  assign scanValid    = scan_valid_q;
  assign frameError   = frame_err_q;
  assign p1Dir        = p1_dir_q;
  assign p2Dir        = p2_dir_q;
  assign startPressed = start_q;

endmodule
